// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the CPU memory subsystem.
//   - cpustate encodings driven by the front panel / control unit
//   - mem_state_t: request FSM states of mem_responder
//   - default address and data widths
package cpu_pkg;

  localparam int unsigned CPU_ADDR_W = 8;
  localparam int unsigned CPU_DATA_W = 8;

  localparam logic [1:0] CS_IDLE  = 2'b00;
  localparam logic [1:0] CS_IN    = 2'b01;
  localparam logic [1:0] CS_CHECK = 2'b10;
  localparam logic [1:0] CS_RUN   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM, read-first.
// Ports:
//   clk    in   rising-edge clock
//   we     in   write enable
//   addr   in   ADDR_W  word address (shared by read and write)
//   wdata  in   DATA_W  write data
//   rdata  out  DATA_W  registered read data (old contents on a write)
// Contents are never reset.
module mem_array
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = CPU_ADDR_W,
  parameter int unsigned DATA_W = CPU_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: byte memory serving CPU read/write strobes (RUN mode) and
// the front-panel loader (IN = fill, CHECK = read back).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cpustate   in  2     00 IDLE, 01 IN, 10 CHECK, 11 RUN
//   addr/wdata in        CPU request address / write data
//   read/write in        CPU request strobes
//   rdata      out       read data, valid with ready on a read; held otherwise
//   ready      out       one-cycle completion pulse
//   busy       out       request in progress
//   ld_valid/ld_data in  loader byte strobe and byte (IN)
//   chk_next   in        loader readback advance (CHECK)
//   ld_addr    out       loader pointer
//   chk_data   out       registered byte at ld_addr
//   err        out       sticky protocol error
// Build option: define WRITE_PROTECT_EN to block RUN writes below PROT_LIMIT.
module mem_responder
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W      = CPU_ADDR_W,
  parameter int unsigned DATA_W      = CPU_DATA_W,
  parameter int unsigned WAIT_STATES = 1
`ifdef WRITE_PROTECT_EN
  ,
  parameter logic [ADDR_W-1:0] PROT_LIMIT = ADDR_W'(8'h10)
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cpustate,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              chk_next,
  output logic [ADDR_W-1:0] ld_addr,
  output logic [DATA_W-1:0] chk_data,
  output logic              err
);

  localparam logic [2:0] WS_LOAD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  mem_state_t        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [1:0]        cs_q;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic              req_wr_q, req_wr_d;
  logic              req_commit_q, req_commit_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] chk_q, chk_d;
  logic              ld_rd_q, ld_rd_d;

  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  logic              req_any;
  logic              accept;
  logic              cs_changed;
  logic              ld_wr;
  logic              protect_hit;

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem_array (
    .clk  (clk),
    .we   (arr_we),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

  always_comb begin
    req_any    = read | write;
    accept     = (state_q == IDLE) && (cpustate == CS_RUN) && req_any;
    cs_changed = (cpustate != cs_q);
`ifdef WRITE_PROTECT_EN
    protect_hit = write && (addr < PROT_LIMIT);
`else
    protect_hit = 1'b0;
`endif

    state_d      = state_q;
    cnt_d        = cnt_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    req_wr_d     = req_wr_q;
    req_commit_d = req_commit_q;
    busy_d       = busy_q;
    ready_d      = 1'b0;
    rdata_d      = rdata_q;
    ld_rd_d      = 1'b0;
    ld_wr        = 1'b0;
    ld_addr_d    = ld_addr_q;

    arr_we    = 1'b0;
    arr_addr  = req_addr_q;
    arr_wdata = req_wdata_q;

    err_d = err_q | (read & write) | (req_any & (cpustate != CS_RUN)) | (accept & protect_hit);

    // Loader pointer: a mode change wins over any strobe in the same cycle.
    if (cs_changed) begin
      ld_addr_d = '0;
    end else if ((state_q == IDLE) && (cpustate == CS_IN) && ld_valid) begin
      ld_wr     = 1'b1;
      ld_addr_d = ld_addr_q + ADDR_W'(1);
    end else if ((state_q == IDLE) && (cpustate == CS_CHECK) && chk_next) begin
      ld_addr_d = ld_addr_q + ADDR_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          req_addr_d   = addr;
          req_wdata_d  = wdata;
          req_wr_d     = write;
          req_commit_d = write & ~protect_hit;
          busy_d       = 1'b1;
          // Start the array read now so data is on arr_rdata by RESP.
          arr_addr     = addr;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            ready_d = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WS_LOAD;
          end
        end else if (ld_wr) begin
          arr_we    = 1'b1;
          arr_addr  = ld_addr_q;
          arr_wdata = ld_data;
        end else begin
          // Read ahead at the next pointer so chk_data trails ld_addr by one cycle.
          arr_addr = ld_addr_d;
          ld_rd_d  = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = RESP;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        arr_we  = req_wr_q & req_commit_q;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (!req_wr_q) begin
          rdata_d = arr_rdata;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    chk_d = ld_rd_q ? arr_rdata : chk_q;

    // A reset edge must not commit anything still in flight.
    if (rst) begin
      arr_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    cs_q <= cpustate;
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_wr_q     <= 1'b0;
      req_commit_q <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
      ld_addr_q    <= '0;
      rdata_q      <= '0;
      chk_q        <= '0;
      ld_rd_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      req_wr_q     <= req_wr_d;
      req_commit_q <= req_commit_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
      ld_addr_q    <= ld_addr_d;
      rdata_q      <= rdata_d;
      chk_q        <= chk_d;
      ld_rd_q      <= ld_rd_d;
    end
  end

  // ready_q is high exactly in RESP; the array output is the registered read then.
  assign rdata    = (ready_q && !req_wr_q) ? arr_rdata : rdata_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign ld_addr  = ld_addr_q;
  assign chk_data = chk_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances share all inputs, index k has
// WAIT_STATES=k, so latency expectations are k+1 cycles.
module tb_mem_responder;

  localparam logic [1:0] M_IDLE  = 2'b00;
  localparam logic [1:0] M_IN    = 2'b01;
  localparam logic [1:0] M_CHECK = 2'b10;
  localparam logic [1:0] M_RUN   = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cpustate;
  logic [7:0] addr, wdata, ld_data;
  logic       read, write, ld_valid, chk_next;

  logic [7:0] rdata_w [2];
  logic [7:0] ld_addr_w [2];
  logic [7:0] chk_w [2];
  logic       ready_w [2];
  logic       busy_w [2];
  logic       err_w [2];

  int tests = 0;
  int fails = 0;

  logic [7:0] mem_m [256];
  logic [7:0] known_q [$];
  bit         err_m;

  int         lat_o [2];
  int         nrdy_o [2];
  logic [7:0] rd_o [2];
  logic       bsy_o [2];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .cpustate(cpustate), .addr(addr), .wdata(wdata),
    .read(read), .write(write), .rdata(rdata_w[0]), .ready(ready_w[0]),
    .busy(busy_w[0]), .ld_valid(ld_valid), .ld_data(ld_data), .chk_next(chk_next),
    .ld_addr(ld_addr_w[0]), .chk_data(chk_w[0]), .err(err_w[0])
  );

  mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(1)) dut1 (
    .clk(clk), .rst(rst), .cpustate(cpustate), .addr(addr), .wdata(wdata),
    .read(read), .write(write), .rdata(rdata_w[1]), .ready(ready_w[1]),
    .busy(busy_w[1]), .ld_valid(ld_valid), .ld_data(ld_data), .chk_next(chk_next),
    .ld_addr(ld_addr_w[1]), .chk_data(chk_w[1]), .err(err_w[1])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic [1:0] m);
    cpustate = m;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    err_m = 1'b0;
  endtask

  // One request pulse, then observe both instances for a bounded window.
  task automatic run_req(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    for (int k = 0; k < 2; k++) begin
      lat_o[k] = 0; nrdy_o[k] = 0; rd_o[k] = '0; bsy_o[k] = 1'b0;
    end
    read = r; write = w; addr = a; wdata = d;
    for (int c = 1; c <= 6; c++) begin
      step();
      read = 1'b0; write = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (c == 1) bsy_o[k] = busy_w[k];
        if (ready_w[k]) begin
          nrdy_o[k] = nrdy_o[k] + 1;
          if (lat_o[k] == 0) begin
            lat_o[k] = c;
            rd_o[k]  = rdata_w[k];
          end
        end
      end
    end
  endtask

  function automatic bit is_protected(input logic [7:0] a);
`ifdef WRITE_PROTECT_EN
    return a < 8'h10;
`else
    return (a != a);
`endif
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    bit seen = 0;
    mem_m[a] = d;
    foreach (known_q[i]) if (known_q[i] == a) seen = 1;
    if (!seen) known_q.push_back(a);
  endtask

  task automatic test_reset();
    read = 0; write = 0; ld_valid = 0; chk_next = 0; addr = 0; wdata = 0; ld_data = 0;
    cpustate = M_IDLE;
    rst = 1'b1;
    step(); step();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if ({rdata_w[k], ready_w[k], busy_w[k], ld_addr_w[k], chk_w[k], err_w[k]} !== 27'd0) begin
        fails++;
        $display("FAIL reset dut%0d: got %h/%b/%b/%h/%h/%b want all zero", k,
                 rdata_w[k], ready_w[k], busy_w[k], ld_addr_w[k], chk_w[k], err_w[k]);
      end
    end
    rst = 1'b0;
    err_m = 1'b0;
  endtask

  task automatic test_load();
    logic [7:0] b;
    set_mode(M_IN);
    for (int i = 0; i < 32; i++) begin
      if (i < 3) b = 8'(8'h10 * (i + 1));
      else b = 8'($urandom_range(0, 255));
      ld_valid = 1'b1; ld_data = b;
      step();
      model_write(8'(i), b);
      if (i == 2) begin
        ld_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
          tests++;
          if (ld_addr_w[k] !== 8'd3 || err_w[k] !== 1'b0) begin
            fails++;
            $display("FAIL load3 dut%0d: ld_addr=%h err=%b want 03/0", k, ld_addr_w[k], err_w[k]);
          end
        end
      end
    end
    ld_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (ld_addr_w[k] !== 8'd32) begin
        fails++;
        $display("FAIL load_ptr dut%0d: got %h want 20", k, ld_addr_w[k]);
      end
    end
  endtask

  task automatic test_check();
    set_mode(M_CHECK);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (ld_addr_w[k] !== 8'd0) begin
        fails++;
        $display("FAIL check_ptr0 dut%0d: got %h want 00", k, ld_addr_w[k]);
      end
    end
    step();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (chk_w[k] !== 8'h10) begin
        fails++;
        $display("FAIL check_data0 dut%0d: got %h want 10", k, chk_w[k]);
      end
    end
    for (int i = 1; i < 32; i++) begin
      chk_next = 1'b1;
      step();
      chk_next = 1'b0;
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (ld_addr_w[k] !== 8'(i)) begin
          fails++;
          $display("FAIL check_ptr dut%0d: got %h want %h", k, ld_addr_w[k], 8'(i));
        end
      end
      step();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (chk_w[k] !== mem_m[i]) begin
          fails++;
          $display("FAIL check_data dut%0d @%0d: got %h want %h", k, i, chk_w[k], mem_m[i]);
        end
      end
    end
    // Run the pointer round past 8'hFF back to zero.
    chk_next = 1'b1;
    for (int i = 0; i < 225; i++) step();
    chk_next = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (ld_addr_w[k] !== 8'd0) begin
        fails++;
        $display("FAIL check_wrap dut%0d: got %h want 00", k, ld_addr_w[k]);
      end
    end
    step();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (chk_w[k] !== mem_m[0]) begin
        fails++;
        $display("FAIL check_wrap_data dut%0d: got %h want %h", k, chk_w[k], mem_m[0]);
      end
    end
  endtask

  task automatic test_run_read();
    set_mode(M_RUN);
    run_req(1'b1, 1'b0, 8'h01, 8'h00);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (lat_o[k] != k + 1 || nrdy_o[k] != 1 || bsy_o[k] !== 1'b1 || rd_o[k] !== 8'h20) begin
        fails++;
        $display("FAIL run_read dut%0d: lat=%0d n=%0d busy=%b data=%h want %0d/1/1/20",
                 k, lat_o[k], nrdy_o[k], bsy_o[k], rd_o[k], k + 1);
      end
      tests++;
      if (busy_w[k] !== 1'b0 || rdata_w[k] !== 8'h20) begin
        fails++;
        $display("FAIL run_read_hold dut%0d: busy=%b rdata=%h want 0/20", k, busy_w[k], rdata_w[k]);
      end
    end
  endtask

  task automatic test_write_read();
    run_req(1'b0, 1'b1, 8'h40, 8'hA5);
    model_write(8'h40, 8'hA5);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (lat_o[k] != k + 1 || nrdy_o[k] != 1) begin
        fails++;
        $display("FAIL wr_lat dut%0d: lat=%0d n=%0d want %0d/1", k, lat_o[k], nrdy_o[k], k + 1);
      end
    end
    run_req(1'b1, 1'b0, 8'h40, 8'h00);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (lat_o[k] != k + 1 || rd_o[k] !== 8'hA5) begin
        fails++;
        $display("FAIL wr_rd dut%0d: lat=%0d data=%h want %0d/a5", k, lat_o[k], rd_o[k], k + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp_n, n [2];
    read = 1'b1; addr = 8'h01;
    n[0] = 0; n[1] = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 6) read = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (ready_w[k]) begin
          n[k] = n[k] + 1;
          tests++;
          if (rdata_w[k] !== mem_m[1]) begin
            fails++;
            $display("FAIL b2b_data dut%0d: got %h want %h", k, rdata_w[k], mem_m[1]);
          end
        end
      end
    end
    // A transaction occupies WAIT_STATES+2 cycles; strobe was seen on edges 1..6.
    for (int k = 0; k < 2; k++) begin
      exp_n = 0;
      for (int e = 1; e <= 6; e++) if ((e - 1) % (k + 2) == 0) exp_n++;
      tests++;
      if (n[k] != exp_n) begin
        fails++;
        $display("FAIL b2b_count dut%0d: got %0d want %0d", k, n[k], exp_n);
      end
    end
  endtask

  task automatic test_random_run();
    logic [7:0] a, d;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = 8'($urandom_range(0, 255));
        d = 8'($urandom_range(0, 255));
        run_req(1'b0, 1'b1, a, d);
        if (is_protected(a)) err_m = 1'b1;
        else model_write(a, d);
        for (int k = 0; k < 2; k++) begin
          tests++;
          if (lat_o[k] != k + 1 || nrdy_o[k] != 1) begin
            fails++;
            $display("FAIL rnd_wr dut%0d @%h: lat=%0d n=%0d want %0d/1", k, a, lat_o[k], nrdy_o[k], k + 1);
          end
        end
      end else begin
        a = known_q[$urandom_range(0, known_q.size() - 1)];
        run_req(1'b1, 1'b0, a, 8'h00);
        for (int k = 0; k < 2; k++) begin
          tests++;
          if (lat_o[k] != k + 1 || rd_o[k] !== mem_m[a]) begin
            fails++;
            $display("FAIL rnd_rd dut%0d @%h: lat=%0d data=%h want %0d/%h", k, a, lat_o[k], rd_o[k], k + 1, mem_m[a]);
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (err_w[k] !== err_m) begin
        fails++;
        $display("FAIL rnd_err dut%0d: got %b want %b", k, err_w[k], err_m);
      end
    end
  endtask

  task automatic test_errors();
    do_reset();
    run_req(1'b1, 1'b1, 8'h50, 8'h3C);
    model_write(8'h50, 8'h3C);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (nrdy_o[k] != 1 || err_w[k] !== 1'b1) begin
        fails++;
        $display("FAIL rw_both dut%0d: n=%0d err=%b want 1/1", k, nrdy_o[k], err_w[k]);
      end
    end
    run_req(1'b1, 1'b0, 8'h50, 8'h00);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (rd_o[k] !== 8'h3C) begin
        fails++;
        $display("FAIL rw_both_data dut%0d: got %h want 3c", k, rd_o[k]);
      end
    end
    do_reset();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (err_w[k] !== 1'b0) begin
        fails++;
        $display("FAIL err_clear dut%0d: got %b want 0", k, err_w[k]);
      end
    end
    run_req(1'b1, 1'b0, 8'h50, 8'h00);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (rd_o[k] !== 8'h3C) begin
        fails++;
        $display("FAIL mem_kept dut%0d: got %h want 3c", k, rd_o[k]);
      end
    end
    set_mode(M_CHECK);
    run_req(1'b0, 1'b1, 8'h60, 8'h77);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (nrdy_o[k] != 0 || err_w[k] !== 1'b1) begin
        fails++;
        $display("FAIL wr_in_check dut%0d: n=%0d err=%b want 0/1", k, nrdy_o[k], err_w[k]);
      end
    end
    set_mode(M_RUN);
    do_reset();
  endtask

  task automatic test_leave_run();
    int n [2];
    n[0] = 0; n[1] = 0;
    write = 1'b1; addr = 8'h70; wdata = 8'h5A;
    step();
    write = 1'b0;
    cpustate = M_IDLE;
    for (int k = 0; k < 2; k++) if (ready_w[k]) n[k]++;
    for (int c = 0; c < 4; c++) begin
      step();
      for (int k = 0; k < 2; k++) if (ready_w[k]) n[k]++;
    end
    model_write(8'h70, 8'h5A);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (n[k] != 1 || err_w[k] !== 1'b0) begin
        fails++;
        $display("FAIL leave_run dut%0d: n=%0d err=%b want 1/0", k, n[k], err_w[k]);
      end
    end
    run_req(1'b1, 1'b0, 8'h70, 8'h00);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (nrdy_o[k] != 0 || err_w[k] !== 1'b1) begin
        fails++;
        $display("FAIL refused dut%0d: n=%0d err=%b want 0/1", k, nrdy_o[k], err_w[k]);
      end
    end
    set_mode(M_RUN);
    do_reset();
    run_req(1'b1, 1'b0, 8'h70, 8'h00);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (rd_o[k] !== 8'h5A) begin
        fails++;
        $display("FAIL leave_run_data dut%0d: got %h want 5a", k, rd_o[k]);
      end
    end
  endtask

  task automatic test_abort();
    write = 1'b1; addr = 8'h50; wdata = 8'hC3;
    step();
    write = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (ready_w[k] !== 1'b0 || busy_w[k] !== 1'b0) begin
        fails++;
        $display("FAIL abort_out dut%0d: ready=%b busy=%b want 0/0", k, ready_w[k], busy_w[k]);
      end
    end
    step();
    run_req(1'b1, 1'b0, 8'h50, 8'h00);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (rd_o[k] !== mem_m[8'h50]) begin
        fails++;
        $display("FAIL abort_data dut%0d: got %h want %h", k, rd_o[k], mem_m[8'h50]);
      end
    end
  endtask

`ifdef WRITE_PROTECT_EN
  task automatic test_protect();
    do_reset();
    run_req(1'b0, 1'b1, 8'h05, 8'hFF);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (nrdy_o[k] != 1 || err_w[k] !== 1'b1) begin
        fails++;
        $display("FAIL prot_wr dut%0d: n=%0d err=%b want 1/1", k, nrdy_o[k], err_w[k]);
      end
    end
    run_req(1'b1, 1'b0, 8'h05, 8'h00);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (rd_o[k] !== mem_m[5]) begin
        fails++;
        $display("FAIL prot_kept dut%0d: got %h want %h", k, rd_o[k], mem_m[5]);
      end
    end
    run_req(1'b0, 1'b1, 8'h10, 8'h99);
    model_write(8'h10, 8'h99);
    run_req(1'b1, 1'b0, 8'h10, 8'h00);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (rd_o[k] !== 8'h99) begin
        fails++;
        $display("FAIL prot_limit dut%0d: got %h want 99", k, rd_o[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_check();
    test_run_read();
    test_write_read();
    test_back_to_back();
    test_random_run();
    test_errors();
    test_leave_run();
    test_abort();
`ifdef WRITE_PROTECT_EN
    test_protect();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Byte-wide program/data memory that answers the memory requests issued by the CPU control unit over its read/write strobes.
- Also serves the front-panel loader, which fills memory while cpustate=IN and reads it back while cpustate=CHECK.
- Sits between the AR/DR datapath and the on-chip storage array.
- Adds configurable wait states and a ready handshake so that slower storage can be substituted later.

Parameters:
- ADDR_W, 8, address width; storage depth is 2**ADDR_W bytes.
- DATA_W, 8, data width.
- WAIT_STATES, 1, extra cycles between request acceptance and ready; legal range 0..7.
- PROT_LIMIT, 8'h10, first writable address when WRITE_PROTECT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cpustate  in  2  CPU mode: 2'b00 IDLE, 2'b01 IN, 2'b10 CHECK, 2'b11 RUN.
- addr  in  ADDR_W  CPU address, from AR.
- wdata  in  DATA_W  CPU write data, from the bus driven by busmem.
- read  in  1  CPU read request.
- write  in  1  CPU write request.
- rdata  out  DATA_W  read data; valid when ready=1 on a read.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  request in progress.
- ld_valid  in  1  loader byte strobe, used in IN.
- ld_data  in  DATA_W  loader byte.
- chk_next  in  1  loader readback advance, used in CHECK.
- ld_addr  out  ADDR_W  current loader pointer.
- chk_data  out  DATA_W  byte at ld_addr.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (rst=1 at a rising edge):
  - rdata=0, ready=0, busy=0, ld_addr=0, chk_data=0, err=0.
  - FSM goes to IDLE.
  - Storage contents are not cleared.
- FSM states are IDLE, WAIT, RESP.
- IDLE, with cpustate=RUN and read or write high:
  - Latch addr, wdata and the operation.
  - busy=1 from the next cycle.
  - Go to WAIT if WAIT_STATES>0, else go to RESP.
- WAIT:
  - A down-counter loaded with WAIT_STATES-1 decrements each cycle.
  - At 0, go to RESP.
  - New requests are ignored while busy.
- RESP:
  - Write: commit the latched wdata to storage at the latched address.
  - Read: drive rdata from storage at the latched address, registered.
  - ready=1 for exactly this cycle; busy=0 from the next cycle; return to IDLE.
- Latency: request edge to ready = WAIT_STATES+1 cycles (WAIT_STATES=0 gives ready on the cycle after the request).
- rdata holds its last read value until the next read completes.
- read and write sampled high together: treat as write and set err=1 (sticky until rst).
- read/write while cpustate!=RUN: ignored, no ready, err=1.
- IN mode (FSM in IDLE):
  - Each ld_valid writes ld_data to storage at ld_addr, then ld_addr increments.
  - ld_addr wraps from 2**ADDR_W-1 to 0.
- CHECK mode:
  - chk_data is the registered storage byte at ld_addr, updated one cycle after any ld_addr change.
  - chk_next increments ld_addr, with the same wrap.
- ld_addr resets to 0 whenever cpustate changes value, so IN and CHECK both start at address 0.
- cpustate leaves RUN mid-transaction: the transaction still completes through RESP (write committed, ready pulsed). The next request is refused.
- rst mid-transaction: the transaction is aborted, no write is committed, and outputs take their reset values.

Optional Feature:
- Macro: WRITE_PROTECT_EN.
- Defined:
  - A RUN-mode write to an address below PROT_LIMIT is not committed.
  - ready still pulses and err is set.
  - IN-mode loads are never protected.
- Undefined: all addresses are writable; no PROT_LIMIT comparison logic is present.

Decomposition:
- Package cpu_pkg holds:
  - cpustate encodings CS_IDLE=2'b00, CS_IN=2'b01, CS_CHECK=2'b10, CS_RUN=2'b11;
  - FSM state typedef mem_state_t (IDLE, WAIT, RESP);
  - DATA_W and ADDR_W defaults.
- One sub-module, mem_array: a single-port synchronous RAM with write enable, address, wdata and registered rdata.
- mem_responder muxes the CPU and loader access onto mem_array, giving the loader priority only outside RUN.

Test Plan:
- Load: cpustate=IN, ld_valid with bytes 8'h10,8'h20,8'h30 -> memory[0..2] holds those bytes, ld_addr=3, err=0.
- Readback: switch to CHECK -> ld_addr=0 and chk_data=8'h10; chk_next twice -> chk_data=8'h30 one cycle after each step.
- RUN read, WAIT_STATES=1: read at addr=8'h01 -> busy high, ready on the 2nd cycle after the request, rdata=8'h20.
- RUN write then read, WAIT_STATES=0: write wdata=8'hA5 to addr=8'h40, then read 8'h40 -> rdata=8'hA5; each ready arrives 1 cycle after its request.
- Errors:
  - read and write high together -> write committed, err=1;
  - write in CHECK -> no ready, err=1;
  - rst -> err=0.
- WRITE_PROTECT_EN, PROT_LIMIT=8'h10: RUN write 8'hFF to addr 8'h05 -> ready pulses, err=1, memory[5] unchanged. Write to 8'h10 -> committed.
